// File: rtl/score_display.sv
// Binary score to BCD via sequential double-dabble, driving registered active-low
// seven-segment digits with optional leading-zero blanking, overflow saturation and blink.
module score_display #(
  parameter int unsigned WIDTH        = 14,
  parameter int unsigned NUM_DIGITS   = 4,
  parameter bit          LZ_BLANK     = 1'b1,
  parameter int unsigned BLINK_CYCLES = 25000000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load,
  input  logic [WIDTH-1:0]        value,
  input  logic                    blink_en,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [7*NUM_DIGITS-1:0] hex_out
);

  localparam int unsigned BcdW      = 4 * NUM_DIGITS;
  localparam int unsigned HexW      = 7 * NUM_DIGITS;
  // ceil(WIDTH * log10(2)) + 1 digits keeps the conversion exact
  localparam int unsigned AccCalc   = (WIDTH * 30103 + 99999) / 100000 + 1;
  localparam int unsigned AccDigits = (AccCalc > NUM_DIGITS) ? AccCalc : NUM_DIGITS;
  localparam int unsigned AccW      = 4 * AccDigits;
  localparam int unsigned CntW      = $clog2(WIDTH + 1);
  localparam int unsigned BlinkW    = $clog2(BLINK_CYCLES);
  localparam int unsigned CmpW      = (WIDTH > 32) ? WIDTH : 32;

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  function automatic logic [HexW-1:0] reset_hex();
    logic [HexW-1:0] r;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      r[7*i +: 7] = (i == 0 || !LZ_BLANK) ? 7'b1000000 : 7'b1111111;
    end
    return r;
  endfunction

  localparam logic [HexW-1:0] HexReset = reset_hex();
  localparam logic [CmpW-1:0] MaxVal   = CmpW'(pow10(NUM_DIGITS) - 1);

  typedef enum logic [1:0] {StIdle, StShift, StOutput} state_e;

  state_e              state_q;
  logic [AccW-1:0]     acc_q;
  logic [AccW-1:0]     acc_adj;
  logic [WIDTH-1:0]    sr_q;
  logic [CntW-1:0]     bit_cnt_q;
  logic                ovf_q;
  logic [HexW-1:0]     seg_q;
  logic [BlinkW-1:0]   blink_cnt_q;
  logic                blink_phase_q;
  logic [CmpW-1:0]     value_ext;
  logic [BcdW-1:0]     res_bcd;
  logic [HexW-1:0]     res_hex;
  logic [HexW-1:0]     hex_next;
  logic                lz_seen;
  logic                blank_now;

  assign value_ext = CmpW'(value);
  assign busy      = (state_q != StIdle);
  assign blank_now = blink_en && blink_phase_q;

  always_comb begin
    acc_adj = acc_q;
    for (int unsigned i = 0; i < AccDigits; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  // Scan from the top digit; once a nonzero digit is seen all lower digits are shown
  always_comb begin
    res_bcd = ovf_q ? {NUM_DIGITS{4'h9}} : acc_q[BcdW-1:0];
    res_hex = '1;
    lz_seen = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (res_bcd[4*i +: 4] != 4'd0 || i == 0 || ovf_q || !LZ_BLANK) lz_seen = 1'b1;
      res_hex[7*i +: 7] = lz_seen ? seg7(res_bcd[4*i +: 4]) : 7'b1111111;
    end
  end

  assign hex_next = (state_q == StOutput) ? res_hex : seg_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      ovf_q     <= 1'b0;
      seg_q     <= HexReset;
      done      <= 1'b0;
      overflow  <= 1'b0;
      bcd_out   <= '0;
      hex_out   <= HexReset;
    end else begin
      done    <= 1'b0;
      // Blink mask applied at the output register keeps hex_out glitch-free
      hex_out <= blank_now ? '1 : hex_next;
      case (state_q)
        StIdle: begin
          if (load) begin
            sr_q      <= value;
            acc_q     <= '0;
            ovf_q     <= (value_ext > MaxVal);
            bit_cnt_q <= '0;
            state_q   <= StShift;
          end
        end
        StShift: begin
          acc_q     <= {acc_adj[AccW-2:0], sr_q[WIDTH-1]};
          sr_q      <= {sr_q[WIDTH-2:0], 1'b0};
          bit_cnt_q <= bit_cnt_q + 1'b1;
          if (bit_cnt_q == CntW'(WIDTH - 1)) state_q <= StOutput;
        end
        StOutput: begin
          bcd_out  <= res_bcd;
          seg_q    <= res_hex;
          overflow <= ovf_q;
          done     <= 1'b1;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset || !blink_en) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (blink_cnt_q == BlinkW'(BLINK_CYCLES - 1)) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= ~blink_phase_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_score_display.sv
// Scoreboard bench for score_display: two instances (blanking on/off) share stimulus;
// a monitor pops expected results from a queue on every done pulse.
module tb_score_display;

  localparam int unsigned W  = 14;
  localparam int unsigned ND = 4;

  localparam logic [6:0] SegTab [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [27:0] HexRstLz = {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000};
  localparam logic [27:0] HexRstNz = {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};

  typedef struct {
    int          v;
    logic [15:0] bcd;
    logic [27:0] hex;
    logic [27:0] hex_nz;
    logic        ovf;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          load = 1'b0;
  logic          blink_en = 1'b0;
  logic [W-1:0]  value = '0;
  logic          busy, done, overflow;
  logic [15:0]   bcd_out;
  logic [27:0]   hex_out;
  logic          busy_nz, done_nz, overflow_nz;
  logic [15:0]   bcd_out_nz;
  logic [27:0]   hex_out_nz;

  int   total = 0;
  int   passed = 0;
  exp_t sb_q[$];

  always #5 clock = ~clock;

  score_display #(.WIDTH(W), .NUM_DIGITS(ND), .LZ_BLANK(1'b1), .BLINK_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .load(load), .value(value), .blink_en(blink_en),
    .busy(busy), .done(done), .overflow(overflow), .bcd_out(bcd_out), .hex_out(hex_out)
  );

  score_display #(.WIDTH(W), .NUM_DIGITS(ND), .LZ_BLANK(1'b0), .BLINK_CYCLES(4)) dut_nz (
    .clock(clock), .reset(reset), .load(load), .value(value), .blink_en(blink_en),
    .busy(busy_nz), .done(done_nz), .overflow(overflow_nz), .bcd_out(bcd_out_nz),
    .hex_out(hex_out_nz)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [15:0] model_bcd(input int v);
    logic [15:0] r;
    int p;
    p = 1;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = (v > 9999) ? 4'd9 : 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [27:0] model_hex(input int v, input bit lz);
    logic [27:0] r;
    int p;
    p = 1;
    for (int i = 0; i < ND; i++) begin
      if (v > 9999)                  r[7*i +: 7] = SegTab[9];
      else if (lz && i > 0 && v < p) r[7*i +: 7] = 7'b1111111;
      else                           r[7*i +: 7] = SegTab[(v / p) % 10];
      p = p * 10;
    end
    return r;
  endfunction

  function automatic exp_t model(input int v);
    exp_t e;
    e.v      = v;
    e.bcd    = model_bcd(v);
    e.hex    = model_hex(v, 1'b1);
    e.hex_nz = model_hex(v, 1'b0);
    e.ovf    = (v > 9999);
    return e;
  endfunction

  // Caller must be at a negedge; returns at the negedge after busy drops
  task automatic run_load(input int v);
    int busy_cycles;
    load  = 1'b1;
    value = W'(v);
    sb_q.push_back(model(v));
    @(negedge clock);
    load  = 1'b0;
    value = W'($urandom);
    busy_cycles = 0;
    for (int c = 0; c < 40; c++) begin
      if (!busy) break;
      busy_cycles++;
      @(negedge clock);
    end
    check($sformatf("busy_len v=%0d", v), busy_cycles, 15);
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 40; c++) begin
      if (!busy) break;
      @(negedge clock);
    end
    check("wait_idle", {31'b0, busy}, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (done || done_nz) begin
        if (sb_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_done: done=%b done_nz=%b bcd=%0h with no pending load",
                   done, done_nz, bcd_out);
        end else begin
          e = sb_q.pop_front();
          check($sformatf("done_pair v=%0d", e.v), {30'b0, done, done_nz}, 32'h3);
          check($sformatf("bcd v=%0d", e.v), {16'b0, bcd_out}, {16'b0, e.bcd});
          check($sformatf("hex v=%0d", e.v), {4'b0, hex_out}, {4'b0, e.hex});
          check($sformatf("ovf v=%0d", e.v), {31'b0, overflow}, {31'b0, e.ovf});
          check($sformatf("bcd_nz v=%0d", e.v), {16'b0, bcd_out_nz}, {16'b0, e.bcd});
          check($sformatf("hex_nz v=%0d", e.v), {4'b0, hex_out_nz}, {4'b0, e.hex_nz});
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [27:0] shown;
    repeat (3) @(negedge clock);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_ovf", {31'b0, overflow}, 0);
    check("rst_bcd", {16'b0, bcd_out}, 0);
    check("rst_hex", {4'b0, hex_out}, {4'b0, HexRstLz});
    check("rst_hex_nz", {4'b0, hex_out_nz}, {4'b0, HexRstNz});
    reset = 1'b0;
    @(negedge clock);

    // Directed values, issued back to back to exercise acceptance right after done
    run_load(1990);
    run_load(7);
    run_load(12000);
    run_load(0);
    run_load(9999);
    run_load(10000);
    run_load(16383);
    run_load(1);

    // Load while busy must be ignored
    @(negedge clock);
    load  = 1'b1;
    value = W'(42);
    sb_q.push_back(model(42));
    @(negedge clock);
    load = 1'b0;
    repeat (3) @(negedge clock);
    load  = 1'b1;
    value = W'(99);
    @(negedge clock);
    load  = 1'b0;
    value = '0;
    wait_idle();
    repeat (20) @(negedge clock);
    run_load(99);

    // Reset in the middle of a conversion discards it
    @(negedge clock);
    load  = 1'b1;
    value = W'(5);
    @(negedge clock);
    load = 1'b0;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrst_bcd", {16'b0, bcd_out}, 0);
    check("midrst_busy", {31'b0, busy}, 0);
    check("midrst_done", {31'b0, done}, 0);
    check("midrst_ovf", {31'b0, overflow}, 0);
    check("midrst_hex", {4'b0, hex_out}, {4'b0, HexRstLz});
    check("midrst_hex_nz", {4'b0, hex_out_nz}, {4'b0, HexRstNz});
    repeat (20) @(negedge clock);

    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(0, 3) == 0) run_load(int'($urandom_range(9990, 10010)));
      else                           run_load(int'($urandom_range(0, 16383)));
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clock);
    end

    // Blink: 4 cycles shown, 4 cycles blank, starting with shown
    run_load(8);
    @(negedge clock);
    shown    = model_hex(8, 1'b1);
    blink_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clock);
      #1;
      check($sformatf("blink_%0d", i), {4'b0, hex_out},
            {4'b0, (((i - 1) / 4) % 2 == 1) ? 28'hfffffff : shown});
    end
    @(negedge clock);
    blink_en = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clock);
      #1;
      check($sformatf("steady_%0d", i), {4'b0, hex_out}, {4'b0, shown});
    end

    repeat (5) @(negedge clock);
    check("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
